// File: rtl/systolic_drain.sv
// Frame-to-stream drain for a 4x4 systolic result tile.
// Captures a 16-element frame of signed 32-bit results in one cycle and streams
// it out one element per accepted handshake. A new frame can be captured on the
// cycle of the final transfer so back-to-back frames leave no bubble.
// Frames offered while busy are discarded and flagged on a sticky error bit.
`timescale 1ns/1ps
module systolic_drain (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] y_in,
  input  logic         valid_in,
  input  logic         overflow_in,
  output logic         in_ready,
  output logic [31:0]  data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_index,
  output logic         out_last,
  output logic         out_overflow,
  output logic         drop_err,
  input  logic         clear_err
);

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_buf [16];
  logic        r_ovf;
  logic [3:0]  r_idx;
  logic [3:0]  w_idx_next;
  logic        r_drop;

  logic        w_xfer;
  logic        w_at_last;
  logic        w_capture;
  logic        w_drop;

  // Handshake decode, next-state logic and output assignment.
  always_comb begin
    w_at_last    = (r_idx == 4'd15);
    out_valid    = (r_state == StSend);
    w_xfer       = out_valid && out_ready;
    // Busy except when the last element leaves this very cycle.
    in_ready     = (r_state == StIdle) || (w_at_last && out_ready);
    w_capture    = valid_in && in_ready;
    w_drop       = valid_in && !in_ready;
    w_state_next = r_state;
    w_idx_next   = r_idx;

    case (r_state)
      StIdle: begin
        if (w_capture) begin
          w_state_next = StSend;
          w_idx_next   = 4'd0;
        end
      end
      StSend: begin
        if (w_capture) begin
          // Last element leaves and the next frame is loaded together.
          w_state_next = StSend;
          w_idx_next   = 4'd0;
        end else if (w_xfer) begin
          if (w_at_last) begin
            w_state_next = StIdle;
            w_idx_next   = 4'd0;
          end else begin
            w_idx_next = r_idx + 4'd1;
          end
        end
      end
      default: begin
        w_state_next = StIdle;
        w_idx_next   = 4'd0;
      end
    endcase

    data_out     = r_buf[r_idx];
    out_index    = r_idx;
    out_last     = out_valid && w_at_last;
    out_overflow = r_ovf;
    drop_err     = r_drop;
  end

  // State and element index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_idx   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Frame buffer and its overflow tag; loaded only on an accepted frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) begin
        r_buf[k] <= 32'd0;
      end
      r_ovf <= 1'b0;
    end else if (w_capture) begin
      for (int k = 0; k < 16; k++) begin
        r_buf[k] <= y_in[32*k +: 32];
      end
      r_ovf <= overflow_in;
    end
  end

  // Sticky drop flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop <= 1'b0;
    end else if (w_drop) begin
      r_drop <= 1'b1;
    end else if (clear_err) begin
      r_drop <= 1'b0;
    end
  end

endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: reset  input  1  synchronous, active-high; sampled on rising clk edge.
REQ-003: y_in  input  512  signed result frame, 16 x 32-bit two's-complement elements; element k = y_in[32k+31:32k], k=0..15, row-major (row=k/4, col=k%4).
REQ-004: valid_in  input  1  y_in/overflow_in valid this cycle; single-cycle pulse, no hold guaranteed.
REQ-005: overflow_in  input  1  overflow indication associated with the frame on y_in.
REQ-006: in_ready  output  1  combinational; 1 when a valid_in this cycle will be captured.
REQ-007: data_out  output  32  signed element currently offered.
REQ-008: out_valid  output  1  data_out/out_index/out_last/out_overflow valid.
REQ-009: out_ready  input  1  downstream accepts the offered element.
REQ-010: out_index  output  4  element number k of data_out.
REQ-011: out_last  output  1  1 when out_valid and out_index==15.
REQ-012: out_overflow  output  1  overflow_in captured with the current frame; constant over the frame.
REQ-013: drop_err  output  1  sticky; a frame was lost because in_ready was 0.
REQ-014: clear_err  input  1  clears drop_err.

Function
REQ-015: FSM shall have two states, IDLE and SEND.
REQ-016: Transfer on output side shall occur iff out_valid && out_ready in the same cycle.
REQ-017: in_ready shall be 1 in IDLE, and in SEND only when out_index==15 and out_ready==1; 0 otherwise.
REQ-018: IDLE with valid_in=1 -> capture all 512 bits of y_in and overflow_in into a frame buffer, out_index<=0, go to SEND; out_valid rises the next cycle (latency 1).
REQ-019: IDLE with valid_in=0 -> stay IDLE, out_valid=0.
REQ-020: SEND: out_valid=1, data_out = buffer element out_index, out_overflow = captured overflow.
REQ-021: SEND, transfer, out_index<15 -> out_index increments by 1; buffer unchanged.
REQ-022: SEND, out_valid && !out_ready -> all outputs held stable (no data or index change).
REQ-023: SEND, transfer at out_index==15, valid_in=0 -> go IDLE, out_valid=0 next cycle.
REQ-024: SEND, transfer at out_index==15, valid_in=1 -> capture new frame, out_index<=0, stay SEND; no bubble between frames.
REQ-025: valid_in=1 while in_ready=0 -> frame discarded, buffer and index untouched, drop_err<=1 next cycle.
REQ-026: drop_err shall remain 1 until clear_err=1 or reset; if clear_err and a new drop coincide, drop_err shall be 1 (set wins).
REQ-027: Elements shall be passed bit-exact; no sign-extension, saturation or reordering.
REQ-028: out_index shall never exceed 15; exactly 16 transfers per captured frame.

Reset
REQ-029: reset=1 at a clock edge -> state IDLE, out_valid=0, out_index=0, out_last=0, data_out=0, out_overflow=0, drop_err=0, frame buffer cleared to 0.
REQ-030: reset shall take priority over valid_in, out_ready and clear_err in the same cycle; a frame mid-transfer is abandoned without further output.
REQ-031: in_ready during reset cycle is don't-care; first cycle after reset deassertion in_ready=1.

Verification
REQ-032: Reset, then frame element k = k+1 (k=0..15), overflow_in=0, out_ready=1 constant -> out_valid one cycle after valid_in, data_out 1..16 over 16 consecutive cycles, out_last only with 16, then IDLE.
REQ-033: Frame with element k = -(k+1) (0xFFFFFFFF..), out_ready toggling 1/0 -> 16 transfers, data_out held during stalls, values -1..-16 exact, out_index 0..15 in order.
REQ-034: Two frames, second valid_in on the cycle of the first frame's last transfer -> 32 transfers, no out_valid gap, second frame's overflow_in=1 seen as out_overflow=1 only on its elements.
REQ-035: valid_in at out_index=5 of an in-flight frame -> frame ignored, original data continues, drop_err=1 next cycle; clear_err pulse -> drop_err=0.
REQ-036: reset asserted at out_index=7 -> next cycle out_valid=0, out_index=0, drop_err=0; fresh frame afterwards drains from element 0.
